// File: rtl/mac_row_sched.sv
// rtl/mac_row_sched.sv - schedules one shared MAC through ROWS dot products of VEC_LEN terms
// Results leave on a valid/ready stream; the next row starts only after the current result is accepted.
module mac_row_sched #(
  parameter int VEC_LEN   = 16,
  parameter int ROWS      = 8,
  parameter int OUT_WIDTH = 20,
  parameter int IA_W      = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
  parameter int WA_W      = (ROWS * VEC_LEN > 1) ? $clog2(ROWS * VEC_LEN) : 1,
  parameter int RA_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [IA_W-1:0]      in_addr,
  output logic [WA_W-1:0]      w_addr,
  output logic                 mac_enable,
  output logic                 mac_set_sum,
  input  logic [OUT_WIDTH-1:0] mac_out,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [RA_W-1:0]      res_row,
  output logic                 res_valid,
  input  logic                 res_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [IA_W-1:0]      k_q;
  logic [RA_W-1:0]      row_q;
  logic                 done_q;
  logic                 mac_en_q;
  logic                 set_sum_q;
  logic                 res_valid_q;
  logic [OUT_WIDTH-1:0] res_data_q;
  logic [RA_W-1:0]      res_row_q;

  logic last_k;
  logic last_row;
  logic hs;

  assign last_k   = (k_q == IA_W'(VEC_LEN - 1));
  assign last_row = (row_q == RA_W'(ROWS - 1));
  assign hs       = res_valid_q & res_ready;

  always_ff @(posedge CLK) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // done_q blocks a start seen in the very cycle the pass is finishing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !done_q) state_d = S_RUN;
      S_RUN:   if (last_k) state_d = S_FLUSH;
      S_FLUSH: state_d = S_WAIT;
      S_WAIT:  if (hs) state_d = last_row ? S_IDLE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      k_q         <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      set_sum_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
    end else begin
      mac_en_q  <= (state_q == S_RUN);
      set_sum_q <= (state_q == S_RUN) && (k_q == '0);
      done_q    <= (state_q == S_WAIT) && hs && last_row;
      if (state_q == S_RUN) k_q <= last_k ? '0 : k_q + IA_W'(1);
      // FLUSH is the cycle the last term's data sits at the MAC input
      if (state_q == S_FLUSH) begin
        res_data_q  <= mac_out;
        res_row_q   <= row_q;
        res_valid_q <= 1'b1;
      end
      if (state_q == S_WAIT && hs) begin
        res_valid_q <= 1'b0;
        row_q       <= last_row ? '0 : row_q + RA_W'(1);
      end
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    rd_en       = (state_q == S_RUN);
    in_addr     = k_q;
    w_addr      = WA_W'(row_q) * WA_W'(VEC_LEN) + WA_W'(k_q);
    mac_enable  = mac_en_q;
    mac_set_sum = set_sum_q;
    res_data    = res_data_q;
    res_row     = res_row_q;
    res_valid   = res_valid_q;
  end

endmodule

// File: tb/tb_mac_row_sched.sv
// tb/tb_mac_row_sched.sv - directed bench with buffer and MAC models around two scheduler instances
module tb_mac_row_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, res_ready;
  logic busy, done, rd_en, mac_enable, mac_set_sum, res_valid;
  logic [3:0]  in_addr;
  logic [6:0]  w_addr;
  logic [19:0] mac_out, res_data;
  logic [2:0]  res_row;

  logic start_b, res_ready_b;
  logic busy_b, done_b, rd_en_b, mac_enable_b, mac_set_sum_b, res_valid_b;
  logic [0:0]  in_addr_b, w_addr_b, res_row_b;
  logic [19:0] mac_out_b, res_data_b;

  mac_row_sched #(.VEC_LEN(16), .ROWS(8), .OUT_WIDTH(20)) dut_a (
    .CLK(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .in_addr(in_addr), .w_addr(w_addr), .mac_enable(mac_enable), .mac_set_sum(mac_set_sum),
    .mac_out(mac_out), .res_data(res_data), .res_row(res_row), .res_valid(res_valid),
    .res_ready(res_ready));

  mac_row_sched #(.VEC_LEN(1), .ROWS(2), .OUT_WIDTH(20)) dut_b (
    .CLK(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .in_addr(in_addr_b), .w_addr(w_addr_b), .mac_enable(mac_enable_b),
    .mac_set_sum(mac_set_sum_b), .mac_out(mac_out_b), .res_data(res_data_b),
    .res_row(res_row_b), .res_valid(res_valid_b), .res_ready(res_ready_b));

  // buffers with one-cycle read latency and a reference MAC for each instance
  logic [7:0]  in_mem [16];
  logic [7:0]  w_mem  [128];
  logic [7:0]  in_q, w_q;
  logic [19:0] acc, prod;
  always @(posedge clk) if (rd_en) begin in_q <= in_mem[in_addr]; w_q <= w_mem[w_addr]; end
  assign prod    = {12'd0, in_q} * {12'd0, w_q};
  assign mac_out = (mac_set_sum ? 20'd0 : acc) + prod;
  always @(posedge clk) if (mac_enable) acc <= mac_out;

  logic [7:0]  in_b_mem [1];
  logic [7:0]  w_b_mem  [2];
  logic [7:0]  in_b_q, w_b_q;
  logic [19:0] acc_b, prod_b;
  always @(posedge clk) if (rd_en_b) begin in_b_q <= in_b_mem[0]; w_b_q <= w_b_mem[w_addr_b]; end
  assign prod_b    = {12'd0, in_b_q} * {12'd0, w_b_q};
  assign mac_out_b = (mac_set_sum_b ? 20'd0 : acc_b) + prod_b;
  always @(posedge clk) if (mac_enable_b) acc_b <= mac_out_b;

  int done_cnt = 0;
  int done_b_cnt = 0;
  bit log_en = 1'b0;
  logic [6:0] waddr_log [$];
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (done_b) done_b_cnt <= done_b_cnt + 1;
    if (rd_en && log_en) waddr_log.push_back(w_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_row(input int r);
    logic [19:0] s;
    s = 20'd0;
    for (int k = 0; k < 16; k++) s = s + {12'd0, in_mem[k]} * {12'd0, w_mem[r*16+k]};
    return s;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("res_valid_seen", res_valid, 1);
  endtask

  task automatic chk_reset_a();
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);        chk("rst_mac_en", mac_enable, 0);
    chk("rst_set_sum", mac_set_sum, 0); chk("rst_res_valid", res_valid, 0);
    chk("rst_in_addr", in_addr, 0);    chk("rst_w_addr", w_addr, 0);
    chk("rst_res_data", res_data, 0);  chk("rst_res_row", res_row, 0);
  endtask

  task automatic run_pass(input int stall_row, input bit poke);
    int n;
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_busy", busy, 1);       chk("first_rd_en", rd_en, 1);
    chk("first_in_addr", in_addr, 0); chk("first_w_addr", w_addr, 0);
    chk("first_mac_en", mac_enable, 0);
    @(negedge clk);
    chk("term0_mac_en", mac_enable, 1); chk("term0_set_sum", mac_set_sum, 1);
    chk("term1_in_addr", in_addr, 1);
    for (int r = 0; r < 8; r++) begin
      if (r == stall_row) res_ready = 1'b0;
      if (poke && r == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_valid(n);
      if (r == 0) chk("row0_latency", n, 16);
      chk($sformatf("res_data_r%0d", r), res_data, exp_row(r));
      chk($sformatf("res_row_r%0d", r), res_row, r);
      chk("wait_mac_en", mac_enable, 0);
      if (r == stall_row) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_valid", res_valid, 1); chk("stall_rd_en", rd_en, 0);
          chk("stall_data", res_data, exp_row(r)); chk("stall_row", res_row, r);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
      chk("after_hs_valid", res_valid, 0);
      if (r == stall_row) begin
        chk("next_row_rd_en", rd_en, 1);
        chk("next_row_w_addr", w_addr, (r + 1) * 16);
      end
    end
    chk("done_pulse", done, 1);
    chk("done_busy_low", busy, 0);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cleared", done, 0);
    chk("start_on_done_ignored", busy, 0);
    @(negedge clk);
    chk("one_done_per_pass", done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
    start_b = 1'b0; res_ready_b = 1'b1;
    for (int k = 0; k < 16; k++) in_mem[k] = 8'd1;
    for (int i = 0; i < 128; i++) w_mem[i] = 8'(i / 16 + 1);
    in_b_mem[0] = 8'd3; w_b_mem[0] = 8'd5; w_b_mem[1] = 8'd7;
    repeat (3) @(negedge clk);
    chk_reset_a();
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // plain pass: rows give 16,32,...,128
    run_pass(-1, 1'b0);
    // consumer stalls on row 3
    run_pass(3, 1'b0);
    // start while busy and on the done cycle
    run_pass(-1, 1'b1);
    repeat (5) @(negedge clk);
    chk("idle_after_poke", busy, 0);

    // reset during row 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      wait_valid(n);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("row2_rd_en", rd_en, 1);
    chk("row2_w_addr", w_addr, 36);
    n = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_a();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", done_cnt, n);
    run_pass(-1, 1'b0);

    // full-scale data and weight address sequence
    for (int k = 0; k < 16; k++) in_mem[k] = 8'd255;
    for (int i = 0; i < 128; i++) w_mem[i] = 8'd255;
    waddr_log.delete();
    log_en = 1'b1;
    run_pass(-1, 1'b0);
    log_en = 1'b0;
    chk("wide_res_data", res_data, 20'd1040400);
    chk("waddr_count", waddr_log.size(), 128);
    bad = 0;
    for (int i = 0; i < waddr_log.size(); i++) if (waddr_log[i] !== 7'(i)) bad++;
    chk("waddr_sequence", bad, 0);

    // single-term rows: set_sum and capture coincide
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_rd_en", rd_en_b, 1); chk("b_w_addr0", w_addr_b, 0);
    @(negedge clk);
    chk("b_mac_en", mac_enable_b, 1); chk("b_set_sum", mac_set_sum_b, 1);
    @(negedge clk);
    chk("b_valid0", res_valid_b, 1); chk("b_data0", res_data_b, 15); chk("b_row0", res_row_b, 0);
    @(negedge clk);
    chk("b_rd_en_row1", rd_en_b, 1); chk("b_w_addr1", w_addr_b, 1);
    @(negedge clk);
    chk("b_set_sum1", mac_set_sum_b, 1);
    @(negedge clk);
    chk("b_valid1", res_valid_b, 1); chk("b_data1", res_data_b, 21); chk("b_row1", res_row_b, 1);
    @(negedge clk);
    chk("b_done", done_b, 1); chk("b_busy_low", busy_b, 0);
    @(negedge clk);
    chk("b_done_count", done_b_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
